instr_fetch: RTL and testbench

//  Front-end stage feeding the DECODER. Owns the program counter and drives the
//  16-bit instruction ROM (combinational read). Buffers fetched words in a small

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 68 ++++++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the instruction front end: FSM states, instruction width,
// default halt encoding and the prefetch queue entry layout.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int PC_W_MAX = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // pc is stored at its widest supported size; narrower builds zero-extend
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_W_MAX-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched words with flush; flush wins over
// push, and a pop at the same edge is still honoured (it simply empties).
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   hold_q;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW:0]    count;
  logic           pop_ok;
  logic           push_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      // remember the head on display so an empty queue keeps showing it
      if (!empty) hold_q <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push_ok, pop_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by count, so stale
  // contents are never observed and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? hold_q : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: pc register, IDLE/RUN/HALT FSM, redirect handling
// and prefetch queue. Define FETCH_PERF_EN to add the stall_cycles counter.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                 AW         = 5,
  parameter int                 DEPTH      = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter logic [AW-1:0]      RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [AW-1:0]      rom_addr,
  output logic               rom_ce,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [AW-1:0]      instr_pc,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [AW-1:0] pc;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;
  logic          push;
  logic          pop;
  logic          unused_pc_hi;

  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  // a redirect suppresses the push: the word on rom_data is on the old path
  assign push        = (state == RUN) && !redirect_valid && (!q_full || pop);

  assign push_entry.instr = rom_data;
  assign push_entry.pc    = PC_W_MAX'(pc);

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign instr_data   = q_head.instr;
  assign instr_pc     = q_head.pc[AW-1:0];
  assign unused_pc_hi = ^{1'b0, q_head.pc};
  assign rom_addr     = pc;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (redirect_valid || start) state_nxt = RUN;
      RUN:     if (push && (rom_data == HALT_INSTR)) state_nxt = HALT;
      HALT:    if (redirect_valid) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rom_ce = (state == RUN);
    halted = (state == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + 1'b1;
  end

`ifdef FETCH_PERF_EN
  // counts cycles where fetch is ready to run but backpressure blocks it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state == RUN) && q_full && !pop && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, halt,
// pc wrap and async reset. Build with FETCH_PERF_EN to also check stalls.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rom_addr;
  logic        rom_ce;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [4:0]  instr_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles;
`endif

  logic [15:0] rom [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_ce         (rom_ce),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // reset state
    #3;
    check("rst_valid",  instr_valid, 0);
    check("rst_data",   instr_data,  0);
    check("rst_pc",     instr_pc,    0);
    check("rst_rom_ce", rom_ce,      0);
    check("rst_halted", halted,      0);
    check("rst_addr",   rom_addr,    0);
    tick();
    rst = 1'b0;

    // 1: stream at full rate
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_lat_valid", instr_valid, 0);
    check("t1_rom_ce",    rom_ce,      1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", instr_valid, 1);
      check("t1_data",  instr_data,  32'h1000 + i);
      check("t1_pc",    instr_pc,    i);
    end

    // 2: backpressure fills the queue, then drains without gaps
    do_reset();
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t2_valid", instr_valid, 1);
    check("t2_head",  instr_data,  16'h1000);
    check("t2_hpc",   instr_pc,    0);
    check("t2_addr",  rom_addr,    2);
`ifdef FETCH_PERF_EN
    check("t2_stall", stall_cycles, 3);
`endif
    instr_ready = 1'b1;
    tick();
    check("t2_d1", instr_data, 16'h1001);
    check("t2_v1", instr_valid, 1);
    tick();
    check("t2_d2", instr_data, 16'h1002);
    check("t2_v2", instr_valid, 1);
`ifdef FETCH_PERF_EN
    check("t2_stall_hold", stall_cycles, 3);
`endif

    // 3: redirect while queue holds pc3,pc4 and head is popped
    tick();
    check("t3_head", instr_data, 16'h1003);
    check("t3_addr", rom_addr,   5);
    redirect_valid = 1'b1;
    redirect_pc = 5'd20;
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_valid", instr_valid, 0);
    check("t3_hold_data",   instr_data,  16'h1003);
    check("t3_addr_new",    rom_addr,    20);
    tick();
    check("t3_valid", instr_valid, 1);
    check("t3_data",  instr_data,  16'h1014);
    check("t3_pc",    instr_pc,    20);

    // 4: halt encoding at pc7, then resume via redirect
    rom[7] = 16'hFFFF;
    redirect_valid = 1'b1;
    redirect_pc = 5'd5;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t4_d5", instr_data, 16'h1005);
    tick();
    check("t4_d6", instr_data, 16'h1006);
    tick();
    check("t4_halt_data", instr_data, 16'hFFFF);
    check("t4_halt_pc",   instr_pc,   7);
    check("t4_halted",    halted,     1);
    check("t4_rom_ce",    rom_ce,     0);
    tick();
    check("t4_drained",   instr_valid, 0);
    check("t4_addr_hold", rom_addr,    8);
    check("t4_still_halt", halted,     1);
    redirect_valid = 1'b1;
    redirect_pc = 5'd0;
    tick();
    redirect_valid = 1'b0;
    check("t4_resume_halted", halted,   0);
    check("t4_resume_ce",     rom_ce,   1);
    check("t4_resume_addr",   rom_addr, 0);
    tick();
    check("t4_resume_data", instr_data, 16'h1000);
    check("t4_resume_pc",   instr_pc,   0);
    rom[7] = 16'h1007;

    // 5: pc wrap 31 -> 0
    redirect_valid = 1'b1;
    redirect_pc = 5'd31;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t5_d31", instr_data, 16'h101F);
    check("t5_p31", instr_pc,   31);
    tick();
    check("t5_d0", instr_data, 16'h1000);
    check("t5_p0", instr_pc,   0);

    // 6: async reset with a full queue
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t6_full_valid", instr_valid, 1);
    check("t6_full_addr",  rom_addr,    2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid",  instr_valid, 0);
    check("t6_data",   instr_data,  0);
    check("t6_pc",     instr_pc,    0);
    check("t6_rom_ce", rom_ce,      0);
    check("t6_halted", halted,      0);
    check("t6_addr",   rom_addr,    0);
`ifdef FETCH_PERF_EN
    check("t6_stall", stall_cycles, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle_ce",    rom_ce,      0);
    check("t6_idle_valid", instr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
